matmul_input_feeder: RTL and testbench



---
 rtl/matmul_input_feeder_if.sv | 57 +++++
 rtl/matmul_input_feeder.sv | 234 +++++++++++++++++++++++
 tb/tb_matmul_input_feeder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/matmul_input_feeder_if.sv
// -----------------------------------------------------------------------------
// matmul_input_feeder_if
//   Bundles the run handshake, the matrix-RAM read port and the skewed west-edge
//   lanes of the systolic-array input feeder.
//
//   master : feeder side (drives busy/done/ram_addr/lanes, receives start/data)
//   slave  : environment side (controller, RAM model, array)
//
//   Signals
//     start              run request, sampled by the feeder only while idle
//     busy               feeder is running
//     done               one-cycle end-of-run pulse
//     ram_addr           matrix-RAM read address
//     ram_rd_data        matrix-RAM read data (1-cycle latency)
//     matmul_fsm_input   `ROWS lanes, lane r at [r*WORD_SIZE +: WORD_SIZE]
//     matmul_input_valid per-lane valid
//     stall              freeze request (only when FEEDER_STALL_EN is defined)
//
//   `ROWS defaults to 4 when not defined by the build.
// -----------------------------------------------------------------------------
`ifndef ROWS
`define ROWS 4
`endif

interface matmul_input_feeder_if #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                          start;
  logic                          busy;
  logic                          done;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [WORD_SIZE-1:0]          ram_rd_data;
  logic [`ROWS*WORD_SIZE-1:0]    matmul_fsm_input;
  logic [`ROWS-1:0]              matmul_input_valid;
`ifdef FEEDER_STALL_EN
  logic                          stall;

  modport master (
    input  start, ram_rd_data, stall,
    output busy, done, ram_addr, matmul_fsm_input, matmul_input_valid
  );
  modport slave (
    output start, ram_rd_data, stall,
    input  busy, done, ram_addr, matmul_fsm_input, matmul_input_valid
  );
`else
  modport master (
    input  start, ram_rd_data,
    output busy, done, ram_addr, matmul_fsm_input, matmul_input_valid
  );
  modport slave (
    output start, ram_rd_data,
    input  busy, done, ram_addr, matmul_fsm_input, matmul_input_valid
  );
`endif
endinterface

// File: rtl/matmul_input_feeder.sv
// -----------------------------------------------------------------------------
// matmul_input_feeder
//   Reads an input matrix (NUM_VECS vectors of `ROWS words, row-major) from a
//   single-port RAM and drives each vector into the west edge of the
//   weight-stationary systolic array. Each vector is held HOLD_CYCLES clocks on
//   lane 0; lane r is delayed r clocks relative to lane 0. Lanes carry zero
//   data whenever their valid is low.
//
//   Ports
//     clk  : clock
//     rst  : synchronous active-high reset, priority over everything
//     bus  : matmul_input_feeder_if.master (start/busy/done, RAM read port,
//            lane data/valid, optional stall)
//
//   Build option
//     FEEDER_STALL_EN : adds bus.stall; while high, every register in the
//                       feeder holds its value (rst still wins).
//
//   Run timing (no stall): done rises NUM_VECS*(`ROWS+1+HOLD_CYCLES)+`ROWS+1
//   clocks after the edge that accepts start; busy falls one clock later.
// -----------------------------------------------------------------------------
`ifndef ROWS
`define ROWS 4
`endif

module matmul_input_feeder #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_VECS    = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_WIDTH  = $clog2(NUM_VECS*`ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  matmul_input_feeder_if.master bus
);

  localparam int ROWS = `ROWS;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int VEC_W    = $clog2(NUM_VECS + 1);
  localparam int FCNT_W   = $clog2(ROWS + 1);
  localparam int HOLD_MAX = (HOLD_CYCLES > ROWS) ? HOLD_CYCLES : ROWS;
  localparam int HCNT_W   = $clog2(HOLD_MAX + 1);

  localparam logic [VEC_W-1:0]  VEC_LAST       = VEC_W'(NUM_VECS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST      = FCNT_W'(ROWS);
  localparam logic [FCNT_W-1:0] FCNT_ADDR_LAST = FCNT_W'(ROWS - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST      = HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [HCNT_W-1:0] DRAIN_LAST     = HCNT_W'(ROWS - 1);

  // ---------------------------------------------------------------------------
  // Global advance enable: the stall freezes every register in the block.
  // ---------------------------------------------------------------------------
  logic adv;
`ifdef FEEDER_STALL_EN
  assign adv = ~bus.stall;
`else
  assign adv = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [2:0]            state_q, state_d;
  logic [VEC_W-1:0]      vec_q,   vec_d;
  logic [FCNT_W-1:0]     fcnt_q,  fcnt_d;
  logic [HCNT_W-1:0]     hcnt_q,  hcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic [WORD_SIZE-1:0]  stage_q [ROWS];
  logic [WORD_SIZE-1:0]  stage_d [ROWS];

  // FETCH cycle k presents address vec*ROWS+k; the RAM answers one clock
  // later, so stage[k-1] is captured at the end of fetch cycle k and the
  // extra (ROWS-th) cycle exists only to catch the final word.
  // The address register walks linearly: it is incremented during the fetch
  // of a vector and once more on leaving ISSUE, which lands exactly on the
  // next vector's base without a multiplier.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    fcnt_d  = fcnt_q;
    hcnt_d  = hcnt_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    for (int unsigned k = 0; k < ROWS; k++) begin
      stage_d[k] = stage_q[k];
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          vec_d   = '0;
          fcnt_d  = '0;
          hcnt_d  = '0;
          addr_d  = '0;
        end
      end

      FETCH: begin
        for (int unsigned k = 0; k < ROWS; k++) begin
          if (fcnt_q == FCNT_W'(k + 1)) begin
            stage_d[k] = bus.ram_rd_data;
          end
        end
        if (fcnt_q < FCNT_ADDR_LAST) begin
          addr_d = addr_q + 1'b1;
        end
        if (fcnt_q == FCNT_LAST) begin
          state_d = ISSUE;
          fcnt_d  = '0;
          hcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end

      ISSUE: begin
        if (hcnt_q == HOLD_LAST) begin
          hcnt_d = '0;
          vec_d  = vec_q + 1'b1;
          if (vec_q == VEC_LAST) begin
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
            addr_d  = addr_q + 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      DRAIN: begin
        if (hcnt_q == DRAIN_LAST) begin
          state_d = DONE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      DONE: begin
        // First DONE clock raises the registered done pulse; the second
        // drops busy and returns to IDLE, so start is taken the clock after.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      fcnt_q  <= '0;
      hcnt_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < ROWS; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      state_q <= state_d;
      vec_q   <= vec_d;
      fcnt_q  <= fcnt_d;
      hcnt_q  <= hcnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int unsigned k = 0; k < ROWS; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skew lanes
  //   Each lane is a pipe of r+1 {valid,data} registers: r skew stages plus
  //   the output register. The pipe input is zero-filled outside ISSUE, which
  //   both creates the inter-vector gaps and keeps idle lane data at zero.
  // ---------------------------------------------------------------------------
  logic issuing;
  assign issuing = (state_q == ISSUE);

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WORD_SIZE-1:0] lane_data;
    logic [WORD_SIZE:0]   pipe_q [r+1];

    assign lane_data = issuing ? stage_q[r] : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned j = 0; j <= r; j++) begin
          pipe_q[j] <= '0;
        end
      end else if (adv) begin
        pipe_q[0] <= {issuing, lane_data};
        for (int unsigned j = 1; j <= r; j++) begin
          pipe_q[j] <= pipe_q[j-1];
        end
      end
    end

    assign bus.matmul_fsm_input[r*WORD_SIZE +: WORD_SIZE] = pipe_q[r][WORD_SIZE-1:0];
    assign bus.matmul_input_valid[r]                     = pipe_q[r][WORD_SIZE];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ram_addr = addr_q;

endmodule

// File: tb/tb_matmul_input_feeder.sv
// -----------------------------------------------------------------------------
// tb_matmul_input_feeder
//   Directed, self-checking bench for matmul_input_feeder with `ROWS=4,
//   NUM_VECS=2, HOLD_CYCLES=2 and a 1-cycle-latency RAM holding RAM[i]=i+1.
//   Expected per-cycle outputs are derived from the run timing and pushed to a
//   scoreboard queue when start is driven, then popped and compared each clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef ROWS
`define ROWS 4
`endif

module tb_matmul_input_feeder;

  localparam int R      = `ROWS;
  localparam int W      = 16;
  localparam int N      = 2;
  localparam int H      = 2;
  localparam int AW     = $clog2(N*R);
  localparam int P      = R + 1 + H;         // clocks per vector
  localparam int T_DONE = N*P + R + 1;       // done offset from start edge

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_input_feeder_if #(.WORD_SIZE(W), .ADDR_WIDTH(AW)) bus ();

  matmul_input_feeder #(
    .WORD_SIZE  (W),
    .NUM_VECS   (N),
    .HOLD_CYCLES(H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 1-cycle-latency RAM model
  logic [W-1:0] mem [N*R];
  always @(posedge clk) bus.ram_rd_data <= mem[bus.ram_addr];

  typedef struct packed {
    logic           busy;
    logic           done;
    logic [R-1:0]   vld;
    logic [R*W-1:0] lanes;
    logic           chk_addr;
    logic [AW-1:0]  addr;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  // Expected outputs e clocks after the start-accepting edge (stall-free time)
  function automatic exp_t model(input int e);
    exp_t x;
    x.busy     = (e <= T_DONE);
    x.done     = (e == T_DONE);
    x.vld      = '0;
    x.lanes    = '0;
    x.chk_addr = 1'b0;
    x.addr     = '0;
    for (int v = 0; v < N; v++) begin
      for (int r = 0; r < R; r++) begin
        int lo;
        lo = v*P + R + 2 + r;
        if (e >= lo && e <= lo + H - 1) begin
          x.vld[r]         = 1'b1;
          x.lanes[r*W +: W] = W'(v*R + r + 1);
        end
      end
      if (e - v*P >= 0 && e - v*P <= R) begin
        x.chk_addr = 1'b1;
        x.addr     = AW'(v*R + ((e - v*P < R) ? (e - v*P) : (R - 1)));
      end
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push expectations for samples t=0..last, with edges stall_at+1..stall_at+len frozen
  task automatic push_run(input int last, input int stall_at, input int stall_len);
    for (int t = 0; t <= last; t++) begin
      int frozen;
      frozen = 0;
      for (int s = stall_at + 1; s <= stall_at + stall_len; s++) begin
        if (s <= t) frozen++;
      end
      sb.push_back(model(t - frozen));
    end
  endtask

  task automatic sample(input string name, input int t);
    exp_t x;
    string tg;
    tg = $sformatf("%s t=%0d", name, t);
    if (sb.size() == 0) begin
      check({tg, " scoreboard_empty"}, 128'(1), 128'(0));
    end else begin
      x = sb.pop_front();
      check({tg, " busy"},  128'(bus.busy), 128'(x.busy));
      check({tg, " done"},  128'(bus.done), 128'(x.done));
      check({tg, " valid"}, 128'(bus.matmul_input_valid), 128'(x.vld));
      check({tg, " lanes"}, 128'(bus.matmul_fsm_input), 128'(x.lanes));
      if (x.chk_addr) check({tg, " ram_addr"}, 128'(bus.ram_addr), 128'(x.addr));
    end
    check({tg, " addr_range"}, 128'(bus.ram_addr < AW'(N*R - 1) || bus.ram_addr == AW'(N*R - 1)), 128'(1));
  endtask

  // One run; samples t=0..last after the start-accepting edge
  task automatic run(input string name, input bit pre_started, input int mid_start_t,
                     input int stall_at, input int stall_len, input bit chain_next);
    int last;
    last = T_DONE + 1 + stall_len;
    push_run(last, stall_at, stall_len);
    if (!pre_started) begin
      @(negedge clk);
      bus.start = 1'b1;
    end
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      sample(name, t);
      bus.start = (t == mid_start_t) || (chain_next && t == last);
`ifdef FEEDER_STALL_EN
      bus.stall = (stall_len > 0) && (t >= stall_at) && (t < stall_at + stall_len);
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < N*R; i++) mem[i] = W'(i + 1);
    bus.start = 1'b0;
`ifdef FEEDER_STALL_EN
    bus.stall = 1'b0;
`endif

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy",     128'(bus.busy), 128'(0));
    check("reset done",     128'(bus.done), 128'(0));
    check("reset valid",    128'(bus.matmul_input_valid), 128'(0));
    check("reset lanes",    128'(bus.matmul_fsm_input), 128'(0));
    check("reset ram_addr", 128'(bus.ram_addr), 128'(0));

    // Basic run (covers lane skew, hold, address sequence, done timing)
    run("basic", 1'b0, -1, -1, 0, 1'b0);

    // Second start mid-ISSUE of vector 0 must be ignored
    run("start_busy", 1'b0, 5, -1, 0, 1'b0);

    // Reset during FETCH of vector 1
    push_run(8, -1, 0);
    @(negedge clk);
    bus.start = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      @(negedge clk);
      sample("pre_abort", t);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",     128'(bus.busy), 128'(0));
    check("abort done",     128'(bus.done), 128'(0));
    check("abort valid",    128'(bus.matmul_input_valid), 128'(0));
    check("abort ram_addr", 128'(bus.ram_addr), 128'(0));
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      check($sformatf("abort quiet t=%0d", t),
            128'({bus.done, bus.busy, bus.matmul_input_valid}), 128'(0));
    end

    // Fresh run replays from address 0, then a back-to-back run
    run("after_abort", 1'b0, -1, -1, 0, 1'b1);
    run("back_to_back", 1'b1, -1, -1, 0, 1'b0);

`ifdef FEEDER_STALL_EN
    // 3-cycle stall during ISSUE of vector 0
    run("stall", 1'b0, -1, 5, 3, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
